// File: rtl/frame_stream_reader.sv
// Raster-order frame-buffer read engine with optional mirror/flip, feeding an
// Avalon-ST style stream through a credit-controlled show-ahead skid FIFO.
module frame_stream_reader #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int PIX_W      = 12,
    parameter int ADDR_W     = 17,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    input  logic              out_ready,
    output logic              frame_done,
    output logic [7:0]        frame_count
);
    localparam int DEPTH = RD_LATENCY + 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((HEIGHT - 1) * WIDTH);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WIDTH);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t            state_reg, state_next;
    logic              first_reg;
    logic [1:0]        mode_reg;
    logic [ADDR_W-1:0] col_reg, row_reg;

    logic              hmirror, vflip, line_end, frame_end, issue, pop, push;
    logic [ADDR_W-1:0] cur_col, cur_row;
    logic [SUM_W-1:0]  in_flight, occupancy;

    logic [RD_LATENCY-1:0] pipe_valid_reg, pipe_sop_reg, pipe_eop_reg;

    logic [PIX_W+1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PIX_W+1:0]  head;

    // Pixel 0 takes the live mode input; the rest of the frame uses the latched copy.
    always_comb begin
        hmirror   = first_reg ? mode[0] : mode_reg[0];
        vflip     = first_reg ? mode[1] : mode_reg[1];
        cur_col   = first_reg ? (hmirror ? COL_LAST : '0) : col_reg;
        cur_row   = first_reg ? (vflip ? LAST_ROW : '0) : row_reg;
        line_end  = (cur_col == (hmirror ? '0 : COL_LAST));
        frame_end = line_end && (cur_row == (vflip ? '0 : LAST_ROW));

        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            in_flight = in_flight + SUM_W'(pipe_valid_reg[i]);
        pop       = out_valid & out_ready;
        occupancy = SUM_W'(count_reg) + in_flight - SUM_W'(pop);
        issue     = (state_reg == RUN) && (occupancy < SUM_W'(DEPTH));
        push      = pipe_valid_reg[RD_LATENCY-1];

        rd_en   = issue;
        rd_addr = issue ? (cur_row + cur_col) : '0;

        state_next = state_reg;
        case (state_reg)
            IDLE: if (enable) state_next = RUN;
            RUN:  if (issue && frame_end && !enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            first_reg <= 1'b1;
            mode_reg  <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (issue) begin
                if (first_reg)
                    mode_reg <= {vflip, hmirror};
                first_reg <= frame_end;
                if (line_end) begin
                    col_reg <= hmirror ? COL_LAST : '0;
                    row_reg <= vflip ? (cur_row - STEP) : (cur_row + STEP);
                end else begin
                    col_reg <= hmirror ? (cur_col - ADDR_W'(1)) : (cur_col + ADDR_W'(1));
                    row_reg <= cur_row;
                end
            end
        end
    end

    // Tags travel alongside the RAM read so sop/eop line up with the returning data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_reg <= '0;
            pipe_sop_reg   <= '0;
            pipe_eop_reg   <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_sop_reg[i]   <= pipe_sop_reg[i-1];
                pipe_eop_reg[i]   <= pipe_eop_reg[i-1];
            end
            pipe_valid_reg[0] <= issue;
            pipe_sop_reg[0]   <= issue & first_reg;
            pipe_eop_reg[0]   <= issue & frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {pipe_sop_reg[RD_LATENCY-1], pipe_eop_reg[RD_LATENCY-1], rd_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            count_reg  <= count_reg + CNT_W'(push) - CNT_W'(pop);
            frame_done <= pop & out_eop;
            if (pop & out_eop)
                frame_count <= frame_count + 8'd1;
        end
    end

    always_comb begin
        head      = fifo_mem[rd_ptr_reg];
        out_valid = (count_reg != '0);
        out_data  = out_valid ? head[PIX_W-1:0] : '0;
        out_sop   = out_valid & head[PIX_W+1];
        out_eop   = out_valid & head[PIX_W];
    end
endmodule
